dual_ch_udp_framer: RTL and testbench

- Upstream payload stage for the 1G Ethernet/UDP transmitter.
- Accepts two independent 32-bit sample streams (channel 1, channel 2) and buffers each in its own FIFO.
- Emits fixed-length frames on a valid/ready word stream with sop/eop. Each frame is a 3-word header (sync, frame counter/length, timestamp) followed by interleaved ch1/ch2 samples.
- The UDP packetiser consumes this stream as the datagram payload.

---
 rtl/dual_ch_udp_framer_if.sv | 10 +
 rtl/dual_ch_udp_framer.sv | 109 ++++++++++
 tb/tb_dual_ch_udp_framer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_ch_udp_framer_if.sv
// dual_ch_udp_framer_if: framed word stream from the framer to the UDP packetiser
interface dual_ch_udp_framer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
  modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/dual_ch_udp_framer.sv
// dual_ch_udp_framer: buffers two sample streams and emits header+interleaved payload frames
module dual_ch_udp_framer #(
  parameter int          SPF       = 64,
  parameter int          FIFO_AW   = 8,
  parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A
) (
  input  logic                        clk_125,
  input  logic                        reset_all,
  input  logic                        time_clr,
  input  logic [31:0]                 data_1ch,
  input  logic                        wr_data_1ch,
  input  logic [31:0]                 data_2ch,
  input  logic                        wr_data_2ch,
  dual_ch_udp_framer_if.master        stream,
  output logic                        ovf_1ch,
  output logic                        ovf_2ch,
  output logic [15:0]                 frame_cnt
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int IW    = FIFO_AW + 1;
  localparam logic [IW-1:0] spf_c = IW'(SPF);
  localparam logic [15:0]   spf16 = 16'(SPF);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PAY} state_t;
  state_t             state, state_nx;
  logic [31:0]        ts, ts_lat;
  logic [31:0]        mem [2][DEPTH];
  logic [31:0]        din [2];
  logic [FIFO_AW-1:0] wp [2];
  logic [FIFO_AW-1:0] rp [2];
  logic [IW-1:0]      cnt [2];
  logic [1:0]         wr, wr_ok, rd, ovf;
  logic [IW-1:0]      idx, idx_nx;
  logic               xfer, last, start, again, lat;
  assign din[0]  = data_1ch;
  assign din[1]  = data_2ch;
  assign wr      = {wr_data_2ch, wr_data_1ch};
  assign wr_ok   = wr & ~{cnt[1][FIFO_AW], cnt[0][FIFO_AW]};
  assign xfer    = stream.out_valid & stream.out_ready;
  assign last    = state == PAY && idx == IW'(2 * SPF - 1);
  assign rd      = {2{xfer && state == PAY}} & {idx[0], ~idx[0]};
  assign start   = cnt[0] >= spf_c && cnt[1] >= spf_c;
  // at the eop transfer one ch2 sample of the registered count is being popped
  assign again   = cnt[0] >= spf_c && cnt[1] > spf_c;
  assign ovf_1ch = ovf[0];
  assign ovf_2ch = ovf[1];
  always_ff @(posedge clk_125) begin
    for (int c = 0; c < 2; c++)
      if (wr_ok[c]) mem[c][wp[c]] <= din[c];
  end
  always_ff @(posedge clk_125) begin
    if (reset_all) begin
      state     <= IDLE;
      idx       <= '0;
      ts        <= '0;
      ts_lat    <= '0;
      frame_cnt <= '0;
      ovf       <= '0;
      for (int c = 0; c < 2; c++) begin
        wp[c]  <= '0;
        rp[c]  <= '0;
        cnt[c] <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      ts    <= time_clr ? '0 : ts + 32'd1;
      if (lat) ts_lat <= ts;
      if (xfer && last) frame_cnt <= frame_cnt + 16'd1;
      ovf <= ovf | (wr & ~wr_ok);
      for (int c = 0; c < 2; c++) begin
        wp[c]  <= wp[c] + FIFO_AW'(wr_ok[c]);
        rp[c]  <= rp[c] + FIFO_AW'(rd[c]);
        cnt[c] <= cnt[c] + IW'(wr_ok[c]) - IW'(rd[c]);
      end
    end
  end
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    lat      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = HDR0;
        lat      = 1'b1;
      end
      HDR0: if (xfer) state_nx = HDR1;
      HDR1: if (xfer) state_nx = HDR2;
      HDR2: if (xfer) begin
        state_nx = PAY;
        idx_nx   = '0;
      end
      PAY: if (xfer) begin
        idx_nx = idx + IW'(1);
        if (last) begin
          state_nx = again ? HDR0 : IDLE;
          lat      = again;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign stream.out_valid = state != IDLE;
  assign stream.out_sop   = state == HDR0;
  assign stream.out_eop   = last;
  assign stream.out_data  = state == HDR0 ? SYNC_WORD :
                            state == HDR1 ? {frame_cnt, spf16} :
                            state == HDR2 ? ts_lat :
                            state == PAY  ? (idx[0] ? mem[1][rp[1]] : mem[0][rp[0]]) : '0;
endmodule

// File: tb/tb_dual_ch_udp_framer.sv
// tb_dual_ch_udp_framer: randomized scenarios checked against a queue-based frame model
module tb_dual_ch_udp_framer;
  localparam int SPF = 64;
  localparam int FLEN = 3 + 2 * SPF;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;
  logic clk_125 = 0, reset_all = 1, time_clr = 0, wr_data_1ch = 0, wr_data_2ch = 0;
  logic [31:0] data_1ch = 0, data_2ch = 0;
  logic ovf_1ch, ovf_2ch;
  logic [15:0] frame_cnt;
  dual_ch_udp_framer_if bus();
  dual_ch_udp_framer #(.SPF(SPF), .FIFO_AW(8), .SYNC_WORD(SYNC)) dut (
    .clk_125(clk_125), .reset_all(reset_all), .time_clr(time_clr),
    .data_1ch(data_1ch), .wr_data_1ch(wr_data_1ch),
    .data_2ch(data_2ch), .wr_data_2ch(wr_data_2ch),
    .stream(bus), .ovf_1ch(ovf_1ch), .ovf_2ch(ovf_2ch), .frame_cnt(frame_cnt));
  always #4 clk_125 = ~clk_125;
  int checks = 0, errors = 0;
  logic [31:0] m1[$], m2[$];
  logic m_ovf1 = 0, m_ovf2 = 0;
  logic [15:0] fc_model = 0;
  logic [31:0] got_w[$], ts_exp_q[$], exp_w[$];
  logic got_sop[$], got_eop[$], exp_sop[$], exp_eop[$];
  int got_cyc[$];
  logic [31:0] ts_model = 0, pd = 0;
  int cyc = 0, stall_bad = 0;
  logic pv = 0, pxfer = 0, pstall = 0, psop = 0, peop = 0;
  always @(posedge clk_125) ts_model <= (reset_all || time_clr) ? 32'd0 : ts_model + 32'd1;
  always @(negedge clk_125) begin
    cyc++;
    if (pstall && (!bus.out_valid || bus.out_data !== pd || bus.out_sop !== psop || bus.out_eop !== peop))
      stall_bad++;
    if (bus.out_valid && (!pv || pxfer) && bus.out_sop) ts_exp_q.push_back(ts_model - 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      got_w.push_back(bus.out_data);
      got_sop.push_back(bus.out_sop);
      got_eop.push_back(bus.out_eop);
      got_cyc.push_back(cyc);
    end
    pv = bus.out_valid;
    pxfer = bus.out_valid && bus.out_ready;
    pstall = bus.out_valid && !bus.out_ready;
    pd = bus.out_data;
    psop = bus.out_sop;
    peop = bus.out_eop;
  end
  initial begin
    #700000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk_125);
    #2;
  endtask
  task automatic set_ready(input int mode);
    bus.out_ready = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
  endtask
  task automatic clear_mon();
    got_w.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete(); ts_exp_q.delete();
  endtask
  task automatic clear_model();
    m1.delete(); m2.delete(); fc_model = 0; m_ovf1 = 0; m_ovf2 = 0;
  endtask
  task automatic feed(input int n1, input int n2, input bit pat, input int rmode);
    int nmax;
    nmax = n1 > n2 ? n1 : n2;
    for (int i = 0; i < nmax; i++) begin
      wr_data_1ch = i < n1;
      wr_data_2ch = i < n2;
      data_1ch = pat ? 32'(i) : $urandom;
      data_2ch = pat ? 32'h1000 + 32'(i) : $urandom;
      if (wr_data_1ch) begin if (m1.size() < 256) m1.push_back(data_1ch); else m_ovf1 = 1; end
      if (wr_data_2ch) begin if (m2.size() < 256) m2.push_back(data_2ch); else m_ovf2 = 1; end
      set_ready(rmode);
      tick();
    end
    wr_data_1ch = 0;
    wr_data_2ch = 0;
  endtask
  task automatic wait_words(input int n, input int rmode);
    for (int k = 0; k < 4000 && got_w.size() < n; k++) begin
      set_ready(rmode);
      tick();
    end
  endtask
  task automatic build_exp(input int nf);
    exp_w.delete(); exp_sop.delete(); exp_eop.delete();
    for (int f = 0; f < nf; f++) begin
      exp_w.push_back(SYNC); exp_sop.push_back(1); exp_eop.push_back(0);
      exp_w.push_back({fc_model, 16'(SPF)}); exp_sop.push_back(0); exp_eop.push_back(0);
      exp_w.push_back(f < ts_exp_q.size() ? ts_exp_q[f] : 32'hDEAD_BEEF);
      exp_sop.push_back(0); exp_eop.push_back(0);
      for (int s = 0; s < SPF; s++) begin
        exp_w.push_back(m1.size() > 0 ? m1.pop_front() : 32'hBAD1);
        exp_sop.push_back(0); exp_eop.push_back(0);
        exp_w.push_back(m2.size() > 0 ? m2.pop_front() : 32'hBAD2);
        exp_sop.push_back(0); exp_eop.push_back(s == SPF - 1);
      end
      fc_model++;
    end
  endtask
  task automatic test_reset();
    reset_all = 1;
    bus.out_ready = 1;
    repeat (3) tick();
    reset_all = 0;
    clear_model();
    clear_mon();
    stall_bad = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    checks++; if ({bus.out_sop, bus.out_eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop got %b%b exp 00", bus.out_sop, bus.out_eop); end
    checks++; if ({ovf_1ch, ovf_2ch} !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b%b exp 00", ovf_1ch, ovf_2ch); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %h exp 0", frame_cnt); end
  endtask
  task automatic test_single_frame();
    clear_mon();
    feed(SPF, SPF, 1, 1);
    wait_words(FLEN, 1);
    repeat (3) tick();
    checks++; if (ts_exp_q.size() != 1) begin errors++; $display("FAIL single_frames got %0d exp 1", ts_exp_q.size()); end
    build_exp(1);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL single_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL single_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
    checks++; if (frame_cnt !== fc_model) begin errors++; $display("FAIL single_frame_cnt got %0d exp %0d", frame_cnt, fc_model); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_stall();
    clear_mon();
    stall_bad = 0;
    feed(SPF, SPF, 0, 2);
    wait_words(FLEN, 2);
    bus.out_ready = 1;
    repeat (3) tick();
    build_exp(1);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL stall_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
    checks++; if ({ovf_1ch, ovf_2ch} !== {m_ovf1, m_ovf2}) begin errors++; $display("FAIL stall_ovf got %b%b exp %b%b", ovf_1ch, ovf_2ch, m_ovf1, m_ovf2); end
    checks++; if (frame_cnt !== fc_model) begin errors++; $display("FAIL stall_frame_cnt got %0d exp %0d", frame_cnt, fc_model); end
  endtask
  task automatic test_threshold();
    bit saw;
    int n;
    clear_mon();
    feed(SPF, SPF - 1, 0, 1);
    saw = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) saw = 1;
      tick();
    end
    checks++; if (saw) begin errors++; $display("FAIL thresh_early_valid got 1 exp 0"); end
    wr_data_2ch = 1;
    data_2ch = $urandom;
    m2.push_back(data_2ch);
    tick();
    wr_data_2ch = 0;
    n = 1;
    while (!bus.out_valid && n < 10) begin tick(); n++; end
    checks++; if (!bus.out_valid || n > 2) begin errors++; $display("FAIL thresh_latency got %0d cycles exp <=2", n); end
    wait_words(FLEN, 1);
    repeat (3) tick();
    build_exp(1);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL thresh_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL thresh_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    clear_mon();
    stall_bad = 0;
    for (int i = 0; i < 300; i++) begin
      wr_data_1ch = 1;
      data_1ch = $urandom;
      if (m1.size() < 256) m1.push_back(data_1ch); else m_ovf1 = 1;
      bus.out_ready = 0;
      tick();
      if (i == 255) begin checks++; if (ovf_1ch !== 1'b0) begin errors++; $display("FAIL ovf_at_256 got %b exp 0", ovf_1ch); end end
      if (i == 256) begin checks++; if (ovf_1ch !== 1'b1) begin errors++; $display("FAIL ovf_at_257 got %b exp 1", ovf_1ch); end end
    end
    wr_data_1ch = 0;
    checks++; if (ovf_2ch !== 1'b0) begin errors++; $display("FAIL ovf2_clean got %b exp 0", ovf_2ch); end
    feed(0, 4 * SPF, 0, 0);
    wait_words(4 * FLEN, 1);
    repeat (3) tick();
    build_exp(4);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL b2b_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL b2b_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
    if (got_cyc.size() > 0) begin
      checks++;
      if (got_cyc[got_cyc.size() - 1] - got_cyc[0] != 4 * FLEN - 1) begin
        errors++; $display("FAIL b2b_span got %0d cycles exp %0d", got_cyc[got_cyc.size() - 1] - got_cyc[0], 4 * FLEN - 1);
      end
    end
    checks++; if ({ovf_1ch, ovf_2ch} !== {m_ovf1, m_ovf2}) begin errors++; $display("FAIL b2b_ovf got %b%b exp %b%b", ovf_1ch, ovf_2ch, m_ovf1, m_ovf2); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL b2b_stable got %0d changes exp 0", stall_bad); end
  endtask
  task automatic test_timestamp();
    reset_all = 1;
    repeat (2) tick();
    reset_all = 0;
    clear_model();
    clear_mon();
    time_clr = 1;
    tick();
    time_clr = 0;
    repeat (35) tick();
    feed(SPF, SPF, 0, 1);
    wait_words(FLEN, 1);
    repeat (2) tick();
    build_exp(1);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL ts_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL ts_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
    clear_mon();
    feed(SPF, SPF, 0, 1);
    wait_words(10, 1);
    time_clr = 1;
    tick();
    time_clr = 0;
    wait_words(FLEN, 1);
    repeat (2) tick();
    build_exp(1);
    checks++; if (got_w.size() < 3 || got_w[2] !== exp_w[2]) begin errors++; $display("FAIL ts_hold got %h exp %h", got_w.size() < 3 ? 32'h0 : got_w[2], exp_w[2]); end
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL ts_hold_len got %0d exp %0d", got_w.size(), exp_w.size()); end
  endtask
  task automatic test_reset_mid();
    int eops;
    clear_mon();
    feed(SPF, SPF, 0, 1);
    wait_words(3 + 20, 1);
    reset_all = 1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin errors++; $display("FAIL rmid_out got %b/%h exp 0/0", bus.out_valid, bus.out_data); end
    checks++; if ({bus.out_sop, bus.out_eop} !== 2'b00) begin errors++; $display("FAIL rmid_sop_eop got %b%b exp 00", bus.out_sop, bus.out_eop); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rmid_frame_cnt got %0d exp 0", frame_cnt); end
    eops = 0;
    foreach (got_eop[i]) if (got_eop[i]) eops++;
    checks++; if (eops != 0) begin errors++; $display("FAIL rmid_eop got %0d exp 0", eops); end
    reset_all = 0;
    clear_model();
    clear_mon();
    repeat (5) tick();
    checks++; if (bus.out_valid !== 1'b0 || got_w.size() != 0) begin errors++; $display("FAIL rmid_empty got %b/%0d exp 0/0", bus.out_valid, got_w.size()); end
    feed(SPF, SPF, 0, 1);
    wait_words(FLEN, 1);
    repeat (2) tick();
    build_exp(1);
    checks++; if (got_w.size() < 2 || got_w[1] !== 32'h0000_0040) begin errors++; $display("FAIL rmid_hdr1 got %h exp 00000040", got_w.size() < 2 ? 32'h0 : got_w[1]); end
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL rmid_len got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++; $display("FAIL rmid_word[%0d] got %h/%b/%b exp %h/%b/%b", i, got_w[i], got_sop[i], got_eop[i], exp_w[i], exp_sop[i], exp_eop[i]);
      end
    end
    checks++; if (frame_cnt !== fc_model) begin errors++; $display("FAIL rmid_frame_cnt_end got %0d exp %0d", frame_cnt, fc_model); end
  endtask
  initial begin
    bus.out_ready = 0;
    test_reset();
    test_single_frame();
    test_stall();
    test_threshold();
    test_back_to_back();
    test_timestamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
